pipe_stage_reg: RTL and testbench

// - Generic, parametrised inter-stage pipeline register (ID/EX, EX/MEM, MEM/WB) with valid/ready handshake.
// - Splits the payload into a control field and a data field; flush zeroes control (NOP) and drops valid.
// - Sits between any two core stages; hazard unit drives flush, downstream stage drives out_ready (stall).

---
 rtl/pipe_pkg.sv | 33 +++
 rtl/pipe_stage_reg_if.sv | 27 ++
 rtl/pipe_skid_buf.sv | 40 ++++
 rtl/pipe_stage_reg.sv | 87 ++++++++
 tb/tb_pipe_stage_reg.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared constants for the inter-stage pipeline registers: ID/EX bundle widths,
// control-bundle field layout and the NOP control value.
package pipe_pkg;

    localparam int IDEX_CTRL_W = 9;
    localparam int IDEX_DATA_W = 128;
    localparam int OCC_W       = 2;

    localparam logic [IDEX_CTRL_W-1:0] IDEX_NOP_CTRL = '0;

    // ID/EX control bundle layout, LSB first
    localparam int CTRL_ALU_SRC_BIT    = 0;
    localparam int CTRL_MEM_RD_BIT     = 1;
    localparam int CTRL_MEM_WR_BIT     = 2;
    localparam int CTRL_MEM_TO_REG_BIT = 3;
    localparam int CTRL_REG_WR_BIT     = 4;
    localparam int CTRL_BRANCH_BIT     = 5;
    localparam int CTRL_JUMP_BIT       = 6;
    localparam int CTRL_ALU_OP_LSB     = 7;
    localparam int CTRL_ALU_OP_W       = 2;

    typedef struct packed {
        logic [CTRL_ALU_OP_W-1:0] alu_op;
        logic                     jump;
        logic                     branch;
        logic                     reg_wr;
        logic                     mem_to_reg;
        logic                     mem_wr;
        logic                     mem_rd;
        logic                     alu_src;
    } idex_ctrl_t;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Handshake/payload bundle between two pipeline stages; slave modport is the
// stage register, master modport is the surrounding core (or bench).
interface pipe_stage_reg_if #(
    parameter int CTRL_W = pipe_pkg::IDEX_CTRL_W,
    parameter int DATA_W = pipe_pkg::IDEX_DATA_W
);
    logic                       in_valid;
    logic                       in_ready;
    logic [CTRL_W-1:0]          in_ctrl;
    logic [DATA_W-1:0]          in_data;
    logic                       flush;
    logic                       out_valid;
    logic                       out_ready;
    logic [CTRL_W-1:0]          out_ctrl;
    logic [DATA_W-1:0]          out_data;
    logic [pipe_pkg::OCC_W-1:0] occupancy;

    modport master (
        output in_valid, in_ctrl, in_data, flush, out_ready,
        input  in_ready, out_valid, out_ctrl, out_data, occupancy
    );

    modport slave (
        input  in_valid, in_ctrl, in_data, flush, out_ready,
        output in_ready, out_valid, out_ctrl, out_data, occupancy
    );
endinterface

// File: rtl/pipe_skid_buf.sv
// One-entry skid buffer: parks a beat accepted while the output register is
// stalled, and provides a registered in_ready (high while the skid is empty).
module pipe_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         skid_valid,
    output logic         in_ready
);
    logic [W-1:0] skid_q;
    logic         valid_q;
    logic         rdy_q;

    // push and pop are mutually exclusive: push requires in_ready, i.e. an empty skid
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            rdy_q   <= 1'b1;
            skid_q  <= '0;
        end else if (flush || pop) begin
            valid_q <= 1'b0;
            rdy_q   <= 1'b1;
        end else if (push) begin
            valid_q <= 1'b1;
            rdy_q   <= 1'b0;
            skid_q  <= din;
        end
    end

    assign dout       = skid_q;
    assign skid_valid = valid_q;
    assign in_ready   = rdy_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, flush-to-NOP and
// bubble NOP control. Define PIPE_SKID_EN for a skid entry and registered in_ready.
module pipe_stage_reg #(
    parameter int                CTRL_W   = pipe_pkg::IDEX_CTRL_W,
    parameter int                DATA_W   = pipe_pkg::IDEX_DATA_W,
    parameter logic [CTRL_W-1:0] NOP_CTRL = {CTRL_W{1'b0}}
) (
    input logic              clk,
    input logic              reset_n,
    pipe_stage_reg_if.slave  bus
);
    logic              out_valid_q;
    logic [CTRL_W-1:0] out_ctrl_q;
    logic [DATA_W-1:0] out_data_q;
    logic              out_free;
    logic              accept;
    logic              skid_valid;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;

    assign out_free = ~out_valid_q | bus.out_ready;
    assign accept   = bus.in_valid & bus.in_ready;

`ifdef PIPE_SKID_EN
    logic                     skid_push;
    logic                     skid_pop;
    logic                     skid_in_ready;
    logic [CTRL_W+DATA_W-1:0] skid_q;

    assign skid_push = accept & ~out_free;
    assign skid_pop  = skid_valid & out_free;

    pipe_skid_buf #(
        .W(CTRL_W + DATA_W)
    ) u_skid (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush      (bus.flush),
        .push       (skid_push),
        .pop        (skid_pop),
        .din        ({bus.in_ctrl, bus.in_data}),
        .dout       (skid_q),
        .skid_valid (skid_valid),
        .in_ready   (skid_in_ready)
    );

    assign skid_ctrl    = skid_q[CTRL_W+DATA_W-1:DATA_W];
    assign skid_data    = skid_q[DATA_W-1:0];
    assign bus.in_ready = skid_in_ready;
`else
    assign skid_valid   = 1'b0;
    assign skid_ctrl    = NOP_CTRL;
    assign skid_data    = '0;
    assign bus.in_ready = out_free;
`endif

    // Skid beat is older than anything on the input, so it drains first
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_ctrl_q  <= NOP_CTRL;
            out_data_q  <= '0;
        end else if (bus.flush) begin
            out_valid_q <= 1'b0;
            out_ctrl_q  <= NOP_CTRL;
        end else if (out_free) begin
            if (skid_valid) begin
                out_valid_q <= 1'b1;
                out_ctrl_q  <= skid_ctrl;
                out_data_q  <= skid_data;
            end else if (accept) begin
                out_valid_q <= 1'b1;
                out_ctrl_q  <= bus.in_ctrl;
                out_data_q  <= bus.in_data;
            end else begin
                out_valid_q <= 1'b0;
                out_ctrl_q  <= NOP_CTRL;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_ctrl  = out_ctrl_q;
    assign bus.out_data  = out_data_q;
    assign bus.occupancy = {1'b0, out_valid_q} + {1'b0, skid_valid};

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed scenarios plus a random
// valid/ready/flush run against a queue scoreboard (works with or without PIPE_SKID_EN).
module tb_pipe_stage_reg;
    localparam int CW = 9;
    localparam int DW = 128;
`ifdef PIPE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic clk;
    logic reset_n;
    int   n_chk  = 0;
    int   n_pass = 0;

    pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW)) bus ();

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [CW+DW-1:0] sb_q[$];

    // Scoreboard: sampled mid-cycle, models what the next rising edge does
    always @(negedge clk) begin
        logic [CW+DW-1:0] exp_beat;
        int               exp_rdy;
        if (!reset_n) begin
            sb_q.delete();
        end else begin
            n_chk++;
            if (bus.occupancy !== 2'(sb_q.size()))
                $display("FAIL occupancy: got %0d want %0d @%0t", bus.occupancy, sb_q.size(), $time);
            else n_pass++;
            n_chk++;
            if (bus.out_valid !== (sb_q.size() != 0))
                $display("FAIL out_valid: got %b want %b @%0t", bus.out_valid, sb_q.size() != 0, $time);
            else n_pass++;
            if (!bus.out_valid) begin
                n_chk++;
                if (bus.out_ctrl !== 9'h000)
                    $display("FAIL bubble_nop: out_ctrl got %h want 000 @%0t", bus.out_ctrl, $time);
                else n_pass++;
            end
            exp_rdy = SKID ? int'(sb_q.size() < 2) : int'(sb_q.size() == 0 || bus.out_ready);
            n_chk++;
            if (bus.in_ready !== exp_rdy[0])
                $display("FAIL in_ready: got %b want %b @%0t", bus.in_ready, exp_rdy[0], $time);
            else n_pass++;
            if (bus.out_valid && bus.out_ready) begin
                n_chk++;
                if (sb_q.size() == 0) begin
                    $display("FAIL sb_order: got unexpected beat %h want none @%0t", bus.out_data, $time);
                end else begin
                    exp_beat = sb_q.pop_front();
                    if ({bus.out_ctrl, bus.out_data} !== exp_beat)
                        $display("FAIL sb_order: got %h want %h @%0t", {bus.out_ctrl, bus.out_data}, exp_beat, $time);
                    else n_pass++;
                end
            end
            if (bus.flush) sb_q.delete();
            else if (bus.in_valid && bus.in_ready) sb_q.push_back({bus.in_ctrl, bus.in_data});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n       = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_ctrl   = 9'h1FF;
        bus.in_data   = 128'hFF;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        cyc();
        cyc();
        n_chk++;
        if (bus.out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.out_valid); else n_pass++;
        n_chk++;
        if (bus.out_ctrl !== 9'h000) $display("FAIL reset_ctrl: got %h want 000", bus.out_ctrl); else n_pass++;
        n_chk++;
        if (bus.out_data !== 128'h0) $display("FAIL reset_data: got %h want 0", bus.out_data); else n_pass++;
        n_chk++;
        if (bus.occupancy !== 2'd0) $display("FAIL reset_occ: got %0d want 0", bus.occupancy); else n_pass++;
        reset_n      = 1'b1;
        bus.in_valid = 1'b0;
        cyc();
    endtask

    task automatic test_stream();
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            bus.in_valid = 1'b1;
            bus.in_ctrl  = 9'(i);
            bus.in_data  = 128'(i);
            cyc();
            n_chk++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 128'(i))
                $display("FAIL stream_beat: got v=%b d=%0h want v=1 d=%0h", bus.out_valid, bus.out_data, i);
            else n_pass++;
        end
        bus.in_valid = 1'b0;
        cyc();
        n_chk++;
        if (bus.out_valid !== 1'b0) $display("FAIL stream_drain: got %b want 0", bus.out_valid); else n_pass++;
    endtask

    task automatic test_stall();
        logic acc;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_ctrl   = 9'h003;
        bus.in_data   = 128'hA5;
        cyc();
        bus.out_ready = 1'b0;
        bus.in_ctrl   = 9'h005;
        bus.in_data   = 128'h5A;
        #1;
        n_chk++;
        if (bus.in_ready !== SKID) $display("FAIL stall_rdy0: got %b want %b", bus.in_ready, SKID); else n_pass++;
        acc = bus.in_valid & bus.in_ready;
        for (int k = 0; k < 3; k++) begin
            cyc();
            if (acc) bus.in_valid = 1'b0;
            n_chk++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 128'hA5)
                $display("FAIL stall_hold: got v=%b d=%0h want v=1 d=a5", bus.out_valid, bus.out_data);
            else n_pass++;
            n_chk++;
            if (bus.occupancy !== (SKID ? 2'd2 : 2'd1))
                $display("FAIL stall_occ: got %0d want %0d", bus.occupancy, SKID ? 2 : 1);
            else n_pass++;
            n_chk++;
            if (bus.in_ready !== 1'b0) $display("FAIL stall_rdy: got %b want 0", bus.in_ready); else n_pass++;
            #1;
            acc = bus.in_valid & bus.in_ready;
        end
        bus.out_ready = 1'b1;
        cyc();
        bus.in_valid = 1'b0;
        n_chk++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 128'h5A)
            $display("FAIL stall_release: got v=%b d=%0h want v=1 d=5a", bus.out_valid, bus.out_data);
        else n_pass++;
        n_chk++;
        if (bus.in_ready !== 1'b1) $display("FAIL release_rdy: got %b want 1", bus.in_ready); else n_pass++;
        cyc();
        n_chk++;
        if (bus.out_valid !== 1'b0) $display("FAIL stall_empty: got %b want 0", bus.out_valid); else n_pass++;
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_ctrl   = 9'h01F;
        bus.in_data   = 128'h77;
        cyc();
        bus.in_ctrl = 9'h0AA;
        bus.in_data = 128'h99;
        bus.flush   = 1'b1;
        cyc();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        n_chk++;
        if (bus.out_valid !== 1'b0 || bus.out_ctrl !== 9'h000 || bus.occupancy !== 2'd0)
            $display("FAIL flush_kill: got v=%b c=%h o=%0d want v=0 c=000 o=0", bus.out_valid, bus.out_ctrl, bus.occupancy);
        else n_pass++;
        // park a beat behind a stalled one (skid when present), then flush both
        bus.in_valid  = 1'b1;
        bus.in_data   = 128'h11;
        cyc();
        bus.out_ready = 1'b0;
        bus.in_data   = 128'h22;
        cyc();
        bus.in_valid = 1'b0;
        bus.flush    = 1'b1;
        cyc();
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        n_chk++;
        if (bus.out_valid !== 1'b0 || bus.occupancy !== 2'd0)
            $display("FAIL flush_stalled: got v=%b o=%0d want v=0 o=0", bus.out_valid, bus.occupancy);
        else n_pass++;
        cyc();
        n_chk++;
        if (bus.out_valid !== 1'b0) $display("FAIL flush_no_leak: got %b want 0", bus.out_valid); else n_pass++;
    endtask

    task automatic test_bubble();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_ctrl   = 9'h0F2;
        bus.in_data   = 128'h42;
        cyc();
        n_chk++;
        if (bus.out_ctrl !== 9'h0F2) $display("FAIL bubble_load: got %h want 0f2", bus.out_ctrl); else n_pass++;
        bus.in_valid = 1'b0;
        cyc();
        n_chk++;
        if (bus.out_valid !== 1'b0 || bus.out_ctrl !== 9'h000)
            $display("FAIL bubble_ctrl: got v=%b c=%h want v=0 c=000", bus.out_valid, bus.out_ctrl);
        else n_pass++;
    endtask

    task automatic test_reset_stall();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_ctrl   = 9'h011;
        bus.in_data   = 128'h33;
        cyc();
        bus.out_ready = 1'b0;
        bus.in_data   = 128'h44;
        cyc();
        bus.in_valid = 1'b0;
        reset_n      = 1'b0;
        bus.flush    = 1'b1;
        cyc();
        n_chk++;
        if (bus.out_valid !== 1'b0 || bus.out_ctrl !== 9'h000 || bus.out_data !== 128'h0 || bus.occupancy !== 2'd0)
            $display("FAIL reset_stall: got v=%b c=%h d=%0h o=%0d want all 0",
                     bus.out_valid, bus.out_ctrl, bus.out_data, bus.occupancy);
        else n_pass++;
        reset_n       = 1'b1;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        cyc();
        n_chk++;
        if (bus.out_valid !== 1'b0) $display("FAIL reset_stall_idle: got %b want 0", bus.out_valid); else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 10000; i++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_ctrl   = 9'($urandom);
            bus.in_data   = {$urandom, $urandom, $urandom, $urandom};
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.flush     = ($urandom_range(0, 31) == 0);
            cyc();
        end
        bus.in_valid  = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        repeat (4) cyc();
        n_chk++;
        if (sb_q.size() != 0) $display("FAIL random_drain: got %0d beats left want 0", sb_q.size()); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_flush();
        test_bubble();
        test_reset_stall();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
